// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts rising edges of an asynchronous sensor square wave
// over gate windows delimited by gate_tick, and publishes the count of each
// completed window with a one-cycle count_valid pulse.
// Optional build macro GLITCH_FILTER_EN inserts a FILT_LEN-cycle stability
// filter between the synchroniser and the edge detector.
module freq_gate_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             gate_tick,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating add of a single-bit increment: never wraps past CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != CNT_MAX)) begin
      sat_inc = a + CNT_W'(1);
    end else begin
      sat_inc = a;
    end
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_s;
  logic                   prev_q, prev_d;
  logic                   edge_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  // Shift the raw sensor level through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  end

`ifdef GLITCH_FILTER_EN
  localparam int FC_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

  logic            filt_q, filt_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  // Follow the synchronised level only after it has differed for FILT_LEN cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_d = ~filt_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end else begin
      fcnt_d = '0;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level_s = filt_q;
`else
  assign level_s = sync_q[SYNC_STAGES-1];
`endif

  // Rising-edge detection on the conditioned level.
  always_comb begin
    prev_d = level_s;
    edge_s = level_s & ~prev_q;
  end

  // Window FSM: accumulate edges in COUNT, publish and restart on each gate_tick.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        sat_d = 1'b0;
        if (enable) begin
          state_d = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        acc_d = '0;
        sat_d = 1'b0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gate_tick) begin
          state_d = S_COUNT;
        end else begin
          state_d = S_ARM;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          // Abandon the window; published results stay as they were.
          state_d = S_IDLE;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (gate_tick) begin
          // A coincident edge belongs to the closing window.
          count_d = sat_inc(acc_q, edge_s);
          ovf_d   = sat_q | (edge_s & (acc_q == CNT_MAX));
          valid_d = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (edge_s) begin
          if (acc_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            acc_d = acc_q + CNT_W'(1);
          end
        end else begin
          acc_d = acc_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
    busy_d = (state_d == S_COUNT);
  end

  // Conditioning, FSM and output registers.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign count_out   = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (16-bit and 4-bit counters)
// share stimulus; a window-level reference model predicts every output.
module tb_freq_gate_counter;

  localparam int SYNC = 2;
  localparam int FLEN = 4;
`ifdef GLITCH_FILTER_EN
  localparam int FILT = FLEN;
`else
  localparam int FILT = 0;
`endif
  // Cycles from driving a rise until the edge is seen by the window counter.
  localparam int LAT = SYNC + FILT + 1;

  logic        clk = 1'b0;
  logic        reset, gate_tick, enable, sig_in;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic        val16, val4, ovf16, ovf4, busy16, busy4;

  freq_gate_counter #(.CNT_W(16), .SYNC_STAGES(SYNC), .FILT_LEN(FLEN)) dut (
    .clk_100MHz(clk), .reset(reset), .gate_tick(gate_tick), .enable(enable),
    .sig_in(sig_in), .count_out(cnt16), .count_valid(val16),
    .overflow(ovf16), .busy(busy16)
  );

  freq_gate_counter #(.CNT_W(4), .SYNC_STAGES(SYNC), .FILT_LEN(FLEN)) dut4 (
    .clk_100MHz(clk), .reset(reset), .gate_tick(gate_tick), .enable(enable),
    .sig_in(sig_in), .count_out(cnt4), .count_valid(val4),
    .overflow(ovf4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // stimulus state
  logic rst_v, en_v, gt_v, sig_v, sig_last;
  int   cur_w;

  // reference model state
  int          rise_q[$];   // cycle at which each accepted rise reaches the counter
  logic        m_open, m_en_prev;
  int          m_last;
  logic [15:0] h16;
  logic [3:0]  h4;
  logic        o16, o4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare every output.
  task automatic step();
    logic ev;
    int   n;
    if (rst_v && sig_v && !sig_last && (FILT == 0 || cur_w >= FILT))
      rise_q.push_back(cyc + LAT);
    sig_last  = sig_v;
    reset     = rst_v;
    sig_in    = sig_v;
    gate_tick = gt_v;
    enable    = en_v;
    @(posedge clk);
    cyc++;
    #1;
    ev = 1'b0;
    if (!rst_v) begin
      rise_q.delete();
      m_open = 1'b0; m_en_prev = 1'b0;
      h16 = '0; h4 = '0; o16 = 1'b0; o4 = 1'b0;
    end else begin
      if (!en_v) begin
        m_open = 1'b0;
      end else if (gt_v && m_en_prev) begin
        n = 0;
        while (rise_q.size() > 0 && rise_q[0] <= cyc) begin
          if (m_open && rise_q[0] > m_last) n++;
          void'(rise_q.pop_front());
        end
        if (m_open) begin
          ev  = 1'b1;
          h16 = (n > 65535) ? 16'hFFFF : 16'(n);
          o16 = (n > 65535);
          h4  = (n > 15) ? 4'hF : 4'(n);
          o4  = (n > 15);
        end
        m_open = 1'b1;
        m_last = cyc;
      end
      m_en_prev = en_v;
    end
    check("valid16", 32'(val16), 32'(ev));
    check("count16", 32'(cnt16), 32'(h16));
    check("ovf16", 32'(ovf16), 32'(o16));
    check("busy16", 32'(busy16), 32'(m_open));
    check("valid4", 32'(val4), 32'(ev));
    check("count4", 32'(cnt4), 32'(h4));
    check("ovf4", 32'(ovf4), 32'(o4));
    check("busy4", 32'(busy4), 32'(m_open));
  endtask

  task automatic idle(input int n);
    gt_v = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick();
    gt_v = 1'b1;
    step();
    gt_v = 1'b0;
  endtask

  // Square wave: each period is lo cycles low then hi cycles high.
  task automatic run(input int periods, input int hi, input int lo, input int te);
    int c;
    c = 0;
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < lo + hi; i++) begin
        sig_v = (i >= lo);
        cur_w = hi;
        gt_v  = (te > 0) && ((c % te) == te - 1);
        step();
        c++;
      end
    end
    gt_v = 1'b0;
  endtask

  initial begin
    rst_v = 1'b0; en_v = 1'b0; gt_v = 1'b0; sig_v = 1'b0; sig_last = 1'b0;
    cur_w = 1; m_open = 1'b0; m_en_prev = 1'b0; m_last = 0;
    h16 = '0; h4 = '0; o16 = 1'b0; o4 = 1'b0;

    // reset and arm
    idle(5);
    rst_v = 1'b1;
    idle(2);
    en_v = 1'b1;
    idle(3);
    tick();

    // basic count: 1000-cycle windows, 100-cycle sensor period
    run(40, 50, 50, 1000);

    // edge landing one before, on, and one after the gate boundary
    for (int d = -1; d <= 1; d++) begin
      sig_v = 1'b0; idle(20);
      tick();
      run(3, 10, 10, 0);
      sig_v = 1'b0; idle(20);
      sig_v = 1'b1; cur_w = 30; step();
      idle(LAT - 2 + d);
      tick();
      idle(25);
      sig_v = 1'b0; idle(20);
      tick();
    end

    // back-to-back gate ticks
    tick(); tick(); tick();

    // saturation of the narrow counter, then recovery
    sig_v = 1'b0; idle(10);
    tick();
    run(20, 5, 5, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();
    run(3, 5, 5, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();

    // disable mid-window, then re-enable and re-arm
    run(5, 10, 10, 0);
    sig_v = 1'b0; idle(LAT + 2);
    en_v = 1'b0; idle(5);
    run(2, 10, 10, 0);
    en_v = 1'b1;
    run(3, 10, 10, 0);
    sig_v = 1'b0; idle(5);
    tick();
    run(4, 10, 10, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();

    // short glitches, then wide pulses
    run(5, 2, 10, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();
    run(5, 10, 10, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();

    // randomized windows, enables and waveforms
    for (int r = 0; r < 25; r++) begin
      int hi, lo, te, per;
      hi   = $urandom_range(1, 30);
      lo   = $urandom_range(FLEN, 30);
      te   = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(40, 400);
      per  = $urandom_range(3, 12);
      en_v = ($urandom_range(0, 5) != 0);
      run(per, hi, lo, te);
    end

    // reset in the middle of a window
    en_v = 1'b1;
    sig_v = 1'b0; idle(3);
    tick();
    run(3, 10, 10, 0);
    sig_v = 1'b0;
    rst_v = 1'b0; idle(3);
    rst_v = 1'b1; idle(2);
    tick(); tick();
    run(2, 10, 10, 0);
    sig_v = 1'b0; idle(LAT + 2);
    tick();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
